// File: rtl/regfile_wb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// Default address/data widths, the pending-entry record and a one-hot decoder.
package regfile_wb_pkg;

    localparam int WB_AW   = 5;
    localparam int WB_DW   = 32;
    localparam int WB_NREG = 2 ** WB_AW;

    typedef struct packed {
        logic             v;
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

    function automatic logic [WB_NREG-1:0] onehot_addr(input logic [WB_AW-1:0] addr);
        logic [WB_NREG-1:0] oh;
        oh       = '0;
        oh[addr] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_pend_fifo.sv
// Circular buffer of pending multi-cycle results with per-slot valid bits.
// Slots can be invalidated in place (squash) without being popped.
module wb_pend_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       push_v,
    input  logic [AW-1:0]              push_addr,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    input  logic [DEPTH-1:0]           squash,
    output logic [DEPTH-1:0]           ent_v,
    output logic [AW-1:0]              ent_addr [DEPTH],
    output logic                       head_v,
    output logic [AW-1:0]              head_addr,
    output logic [DW-1:0]              head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_reg;
    logic [AW-1:0]    addr_reg [DEPTH];
    logic [DW-1:0]    data_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_reg      <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash[i]) begin
                    v_reg[i] <= 1'b0;
                end
            end
            // Popped slots drop their valid so unoccupied slots never feed the mask.
            if (pop) begin
                v_reg[rd_ptr_reg] <= 1'b0;
                rd_ptr_reg        <= rd_ptr_reg + 1'b1;
            end
            if (push) begin
                v_reg[wr_ptr_reg]    <= push_v;
                addr_reg[wr_ptr_reg] <= push_addr;
                data_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg           <= wr_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            assign ent_addr[gi] = addr_reg[gi];
        end
    endgenerate

    assign ent_v     = v_reg;
    assign head_v    = v_reg[rd_ptr_reg];
    assign head_addr = addr_reg[rd_ptr_reg];
    assign head_data = data_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between the pipeline writeback (A)
// and buffered multi-cycle results (B), with WAW squash and a starvation drain.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4,
    parameter int AW       = WB_AW,
    parameter int DW       = WB_DW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               a_valid,
    input  logic [AW-1:0]      a_addr,
    input  logic [DW-1:0]      a_data,
    output logic               a_stall,
    input  logic               b_valid,
    output logic               b_ready,
    input  logic [AW-1:0]      b_addr,
    input  logic [DW-1:0]      b_data,
    output logic               RegWrite,
    output logic [AW-1:0]      RDaddr,
    output logic [DW-1:0]      RDdata,
    output logic [2**AW-1:0]   pend_mask
);

    localparam int NREG = 2 ** AW;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int WW   = $clog2(MAX_WAIT + 1);

    logic [DEPTH-1:0] ent_v;
    logic [AW-1:0]    ent_addr [DEPTH];
    logic             head_v;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_data;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] squash;
    logic [WW-1:0]    wait_reg;
    logic [WW-1:0]    wait_next;
    logic [NREG-1:0]  mask_next;

    logic fifo_empty;
    logic head_live;
    logic pop;
    logic push;
    logic push_v;
    logic grant_a;
    logic grant_b;
    logic force_drain;

    assign fifo_empty = (count == '0);
    assign head_live  = !fifo_empty && head_v;
    assign b_ready    = rst_n && (count < CW'(DEPTH));
    assign push       = b_valid && b_ready;
    // A is always younger, so a same-cycle B result to the same register is dead on arrival.
    assign push_v     = (b_addr != '0) && !(grant_a && (b_addr == a_addr));

    always_comb begin
        pop         = 1'b0;
        grant_a     = 1'b0;
        grant_b     = 1'b0;
        force_drain = 1'b0;
        if (rst_n) begin
            if (!fifo_empty && !head_v) begin
                pop     = 1'b1;
                grant_a = a_valid && (a_addr != '0);
            end else if (head_live && (wait_reg == WW'(MAX_WAIT))) begin
                grant_b     = 1'b1;
                pop         = 1'b1;
                force_drain = 1'b1;
            end else if (a_valid && (a_addr != '0)) begin
                grant_a = 1'b1;
            end else if (head_live) begin
                // Covers both an idle pipeline and an A write to r0, which needs no port.
                grant_b = 1'b1;
                pop     = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_squash
            assign squash[gi] = grant_a && ent_v[gi] && (ent_addr[gi] == a_addr);
        end
    endgenerate

    wb_pend_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_v    (push_v),
        .push_addr (b_addr),
        .push_data (b_data),
        .pop       (pop),
        .squash    (squash),
        .ent_v     (ent_v),
        .ent_addr  (ent_addr),
        .head_v    (head_v),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (count)
    );

    always_comb begin
        wait_next = wait_reg;
        if (pop || fifo_empty) begin
            wait_next = '0;
        end else if (head_live && !grant_b && (wait_reg != WW'(MAX_WAIT))) begin
            wait_next = wait_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_reg <= '0;
        end else begin
            wait_reg <= wait_next;
        end
    end

    always_comb begin
        mask_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_v[i]) begin
                mask_next[ent_addr[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        RegWrite  = grant_a || grant_b;
        RDaddr    = '0;
        RDdata    = '0;
        if (grant_a) begin
            RDaddr = a_addr;
            RDdata = a_data;
        end else if (grant_b) begin
            RDaddr = head_addr;
            RDdata = head_data;
        end
        a_stall   = force_drain;
        pend_mask = rst_n ? mask_next : '0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scoreboard bench: the driver queues the expected port state for each
// cycle it drives; a negedge monitor pops and compares independently.
module tb_regfile_wb_arbiter;
    import regfile_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_stall;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        RegWrite;
    logic [4:0]  RDaddr;
    logic [31:0] RDdata;
    logic [31:0] pend_mask;

    typedef struct {
        string       name;
        wb_entry_t   wr;
        logic        stall;
        logic        rdy;
        logic [31:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DEPTH    (2),
        .MAX_WAIT (4),
        .AW       (5),
        .DW       (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_stall   (a_stall),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .RegWrite  (RegWrite),
        .RDaddr    (RDaddr),
        .RDdata    (RDdata),
        .pend_mask (pend_mask)
    );

    task automatic step(input string name, input logic rst,
                        input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                        input logic we, input logic [4:0] ea, input logic [31:0] ed,
                        input logic st, input logic rdy, input logic [31:0] m);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n   = rst;
        a_valid = av;
        a_addr  = aa;
        a_data  = ad;
        b_valid = bv;
        b_addr  = ba;
        b_data  = bd;
        e.name  = name;
        e.wr    = '{v: we, addr: ea, data: ed};
        e.stall = st;
        e.rdy   = rdy;
        e.mask  = m;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (RegWrite !== e.wr.v || RDaddr !== e.wr.addr || RDdata !== e.wr.data ||
                a_stall !== e.stall || b_ready !== e.rdy || pend_mask !== e.mask) begin
                errors++;
                $display("FAIL %s: got we=%b addr=%0d data=%h stall=%b rdy=%b mask=%h, expected we=%b addr=%0d data=%h stall=%b rdy=%b mask=%h",
                         e.name, RegWrite, RDaddr, RDdata, a_stall, b_ready, pend_mask,
                         e.wr.v, e.wr.addr, e.wr.data, e.stall, e.rdy, e.mask);
            end else begin
                $display("ok   %s: we=%b addr=%0d data=%h stall=%b rdy=%b mask=%h",
                         e.name, RegWrite, RDaddr, RDdata, a_stall, b_ready, pend_mask);
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        a_valid = 1'b1;
        a_addr  = 5'd5;
        a_data  = 32'h1;
        b_valid = 1'b1;
        b_addr  = 5'd6;
        b_data  = 32'h66;

        //    name         rst av aa     ad            bv ba     bd        we ea     ed            st rdy mask
        step("rst0",       0,  1, 5'd5,  32'h1,        1, 5'd6,  32'h66,   0, 5'd0,  32'h0,        0, 0, 32'h0);
        step("rst1",       0,  1, 5'd5,  32'h1,        1, 5'd6,  32'h66,   0, 5'd0,  32'h0,        0, 0, 32'h0);
        step("rst2",       0,  1, 5'd5,  32'h1,        1, 5'd6,  32'h66,   0, 5'd0,  32'h0,        0, 0, 32'h0);
        step("idle",       1,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        0, 1, 32'h0);
        step("a_only",     1,  1, 5'd5,  32'hDEAD,     0, 5'd0,  32'h0,    1, 5'd5,  32'hDEAD,     0, 1, 32'h0);
        step("b_enq7",     1,  0, 5'd0,  32'h0,        1, 5'd7,  32'h11,   0, 5'd0,  32'h0,        0, 1, 32'h0);
        step("b_wr7",      1,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 5'd7,  32'h11,       0, 1, onehot_addr(5'd7));
        step("after7",     1,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        0, 1, 32'h0);
        step("b_enq3",     1,  0, 5'd0,  32'h0,        1, 5'd3,  32'h33,   0, 5'd0,  32'h0,        0, 1, 32'h0);
        for (int k = 0; k < 4; k++)
            step("bypass",  1,  1, 5'd9,  32'h99,       0, 5'd0,  32'h0,    1, 5'd9,  32'h99,       0, 1, onehot_addr(5'd3));
        step("drain3",     1,  1, 5'd9,  32'h99,       0, 5'd0,  32'h0,    1, 5'd3,  32'h33,       1, 1, onehot_addr(5'd3));
        step("resume9",    1,  1, 5'd9,  32'h99,       0, 5'd0,  32'h0,    1, 5'd9,  32'h99,       0, 1, 32'h0);
        step("b_enq4",     1,  0, 5'd0,  32'h0,        1, 5'd4,  32'h44,   0, 5'd0,  32'h0,        0, 1, 32'h0);
        step("a_sq4",      1,  1, 5'd4,  32'hA4,       0, 5'd0,  32'h0,    1, 5'd4,  32'hA4,       0, 1, onehot_addr(5'd4));
        step("pop_dead4",  1,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        0, 1, 32'h0);
        step("empty4",     1,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        0, 1, 32'h0);
        step("b_enq8",     1,  1, 5'd10, 32'hAA,       1, 5'd8,  32'h88,   1, 5'd10, 32'hAA,       0, 1, 32'h0);
        step("b_enq0",     1,  1, 5'd10, 32'hAA,       1, 5'd0,  32'h0,    1, 5'd10, 32'hAA,       0, 1, onehot_addr(5'd8));
        step("full_ign",   1,  1, 5'd10, 32'hAA,       1, 5'd12, 32'hCC,   1, 5'd10, 32'hAA,       0, 0, onehot_addr(5'd8));
        step("full_wr8",   1,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 5'd8,  32'h88,       0, 0, onehot_addr(5'd8));
        step("pop_r0",     1,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        0, 1, 32'h0);
        step("empty0",     1,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        0, 1, 32'h0);
        step("b_enq13",    1,  1, 5'd11, 32'hB1,       1, 5'd13, 32'hD,    1, 5'd11, 32'hB1,       0, 1, 32'h0);
        step("a_r0_b13",   1,  1, 5'd0,  32'hFF,       0, 5'd0,  32'h0,    1, 5'd13, 32'hD,        0, 1, onehot_addr(5'd13));
        step("after13",    1,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        0, 1, 32'h0);
        step("same_cyc14", 1,  1, 5'd14, 32'hE1,       1, 5'd14, 32'hE,    1, 5'd14, 32'hE1,       0, 1, 32'h0);
        step("pop_dead14", 1,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        0, 1, 32'h0);
        step("empty14",    1,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        0, 1, 32'h0);
        step("b_enq15",    1,  1, 5'd11, 32'hB1,       1, 5'd15, 32'hF,    1, 5'd11, 32'hB1,       0, 1, 32'h0);
        step("mid_rst",    0,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        0, 0, 32'h0);
        step("post_rst",   1,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        0, 1, 32'h0);
        step("post_rst2",  1,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        0, 1, 32'h0);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++)
            @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
